// File: rtl/coin_acceptor.sv
// Coin-sensor front end: synchronises, debounces and qualifies two coin slots into a one-cycle code.
// Optional running deposit counter enabled by defining COIN_ACCEPTOR_TOTAL_EN.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int TOTAL_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin5_raw,
    input  logic               coin10_raw,
    input  logic               accept_en,
`ifdef COIN_ACCEPTOR_TOTAL_EN
    input  logic               total_clr,
    output logic [TOTAL_W-1:0] coin_total,
`endif
    output logic [1:0]         in_code,
    output logic               reject
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [1:0]       CODE_5  = 2'b01;
    localparam logic [1:0]       CODE_10 = 2'b10;

    // Elaboration-time parameter sanity checks.
    if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_debounce
        $error("coin_acceptor: DEBOUNCE_CYCLES out of range");
    end
    if ((CNT_W < 1) || (CNT_W > 31) || (DEBOUNCE_CYCLES >= (1 << CNT_W))) begin : g_bad_cnt_w
        $error("coin_acceptor: CNT_W cannot hold DEBOUNCE_CYCLES");
    end
    if (TOTAL_W < 1) begin : g_bad_total_w
        $error("coin_acceptor: TOTAL_W must be at least 1");
    end

    // Two-flop synchronisers for the asynchronous sensor lines.
    logic       r_s5_meta;
    logic       r_s5;
    logic       r_s10_meta;
    logic       r_s10;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic       r_slot10;
    logic       w_slot10_nxt;
    logic [1:0] r_in_code;
    logic [1:0] w_code_nxt;
    logic       r_reject;
    logic       w_reject_nxt;

    logic       w_latched;
    logic       w_other;

    assign w_latched = r_slot10 ? r_s10 : r_s5;
    assign w_other   = r_slot10 ? r_s5  : r_s10;

    // NOTE: reset is synchronous here, so it lives inside the clocked branch and
    // every state element uses non-blocking assignment to avoid ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s5_meta  <= 1'b0;
            r_s5       <= 1'b0;
            r_s10_meta <= 1'b0;
            r_s10      <= 1'b0;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_slot10   <= 1'b0;
            r_in_code  <= 2'b00;
            r_reject   <= 1'b0;
        end else begin
            r_s5_meta  <= coin5_raw;
            r_s5       <= r_s5_meta;
            r_s10_meta <= coin10_raw;
            r_s10      <= r_s10_meta;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_slot10   <= w_slot10_nxt;
            r_in_code  <= w_code_nxt;
            r_reject   <= w_reject_nxt;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_slot10_nxt = r_slot10;
        w_code_nxt   = 2'b00;
        w_reject_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (r_s5 && r_s10) begin
                    w_reject_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = WAIT_RELEASE;
                end else if (r_s5 || r_s10) begin
                    w_slot10_nxt = r_s10;
                    w_cnt_nxt    = CNT_ONE;
                    w_state_nxt  = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (!w_latched) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_other) begin
                    w_reject_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = WAIT_RELEASE;
                end else if (r_cnt == DB_MAX) begin
                    if (accept_en) begin
                        w_code_nxt = r_slot10 ? CODE_10 : CODE_5;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            WAIT_RELEASE: begin
                // A held coin keeps restarting the release count, so it yields one code only.
                if (r_s5 || r_s10) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DB_MAX) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_code = r_in_code;
    assign reject  = r_reject;

`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic [TOTAL_W-1:0] r_total;
    logic [1:0]         w_inc;
    logic [TOTAL_W:0]   w_sum;

    assign w_inc = (w_code_nxt == CODE_10) ? 2'd2 :
                   (w_code_nxt == CODE_5)  ? 2'd1 : 2'd0;
    assign w_sum = {1'b0, r_total} + (TOTAL_W + 1)'(w_inc);

    // Saturate at all-ones; clear takes priority over a same-edge increment.
    always_ff @(posedge clk) begin
        if (rst || total_clr) begin
            r_total <= '0;
        end else if (w_sum[TOTAL_W]) begin
            r_total <= '1;
        end else begin
            r_total <= w_sum[TOTAL_W-1:0];
        end
    end

    assign coin_total = r_total;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor (DEBOUNCE_CYCLES = 4): per-cycle vector table plus
// hand-written deposit-total sequence when COIN_ACCEPTOR_TOTAL_EN is defined.
module tb_coin_acceptor;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic       coin5_raw;
    logic       coin10_raw;
    logic       accept_en;
    logic [1:0] in_code;
    logic       reject;
`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic       total_clr;
    logic [2:0] coin_total;
`endif

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (8),
        .TOTAL_W        (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coin5_raw (coin5_raw),
        .coin10_raw(coin10_raw),
        .accept_en (accept_en),
`ifdef COIN_ACCEPTOR_TOTAL_EN
        .total_clr (total_clr),
        .coin_total(coin_total),
`endif
        .in_code   (in_code),
        .reject    (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       c5;
        logic       c10;
        logic       en;
        logic       rst;
        logic [1:0] exp_code;
        logic       exp_rej;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Append n identical cycles; expected values are the outputs right after that cycle's edge.
    task automatic push(input int n, input logic c5, input logic c10, input logic en,
                        input logic r, input logic [1:0] code, input logic rej, input string nm);
        vec_t v;
        v.c5 = c5; v.c10 = c10; v.en = en; v.rst = r;
        v.exp_code = code; v.exp_rej = rej; v.name = nm;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic c5, input logic c10, input logic en, input logic r);
        @(negedge clk);
        coin5_raw  = c5;
        coin10_raw = c10;
        accept_en  = en;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

`ifdef COIN_ACCEPTOR_TOTAL_EN
    task automatic insert_coin(input logic is10, input logic [2:0] exp_total);
        for (int k = 0; k < 8; k++)  step(!is10, is10, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check($sformatf("coin_total after %s coin", is10 ? "10" : "5"), 32'(coin_total), 32'(exp_total));
    endtask
`endif

    initial begin
        rst        = 1'b1;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        accept_en  = 1'b1;
`ifdef COIN_ACCEPTOR_TOTAL_EN
        total_clr  = 1'b0;
`endif

        //    n  c5 c10 en rst code rej  name
        push(2,  0, 0, 1, 1, 2'b00, 0, "reset");
        push(20, 0, 0, 1, 0, 2'b00, 0, "idle");
        // Clean 5 rs coin: raw sampled at edge N, code registered at edge N+6.
        push(6,  1, 0, 1, 0, 2'b00, 0, "c5 debounce");
        push(1,  1, 0, 1, 0, 2'b01, 0, "c5 qualify");
        push(8,  1, 0, 1, 0, 2'b00, 0, "c5 held");
        push(10, 0, 0, 1, 0, 2'b00, 0, "c5 release");
        // Two-cycle glitch on the 10 rs line is filtered.
        push(2,  0, 1, 1, 0, 2'b00, 0, "glitch");
        push(8,  0, 0, 1, 0, 2'b00, 0, "glitch after");
        // Both lines together: one reject at edge N+2.
        push(2,  1, 1, 1, 0, 2'b00, 0, "both sync");
        push(1,  1, 1, 1, 0, 2'b00, 1, "both reject");
        push(3,  1, 1, 1, 0, 2'b00, 0, "both held");
        // Only 3 low cycles, then a coin: still in WAIT_RELEASE, so ignored.
        push(3,  0, 0, 1, 0, 2'b00, 0, "short gap");
        push(10, 1, 0, 1, 0, 2'b00, 0, "early coin ignored");
        // 5 low cycles is just enough; the next coin is accepted.
        push(5,  0, 0, 1, 0, 2'b00, 0, "min gap");
        push(6,  0, 1, 1, 0, 2'b00, 0, "c10 debounce");
        push(1,  0, 1, 1, 0, 2'b10, 0, "c10 qualify");
        push(3,  0, 1, 1, 0, 2'b00, 0, "c10 held");
        push(10, 0, 0, 1, 0, 2'b00, 0, "c10 release");
        // Second line rising while debouncing the first: reject.
        push(2,  1, 0, 1, 0, 2'b00, 0, "c5 start");
        push(2,  1, 1, 1, 0, 2'b00, 0, "c10 joins");
        push(1,  1, 1, 1, 0, 2'b00, 1, "other-line reject");
        push(4,  1, 1, 1, 0, 2'b00, 0, "both held 2");
        push(12, 0, 0, 1, 0, 2'b00, 0, "release 2");
        // Disabled: a valid 10 rs coin gives one reject at the qualify edge.
        push(6,  0, 1, 0, 0, 2'b00, 0, "dis debounce");
        push(1,  0, 1, 0, 0, 2'b00, 1, "dis reject");
        push(3,  0, 1, 0, 0, 2'b00, 0, "dis held");
        push(10, 0, 0, 1, 0, 2'b00, 0, "dis release");
        // Reset while debouncing a second coin: nothing emitted.
        push(3,  1, 0, 1, 0, 2'b00, 0, "pre-reset coin");
        push(1,  1, 0, 1, 1, 2'b00, 0, "mid-debounce reset");
        push(12, 0, 0, 1, 0, 2'b00, 0, "post-reset");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c5, vecs[i].c10, vecs[i].en, vecs[i].rst);
            check($sformatf("vec[%0d] %s in_code", i, vecs[i].name), 32'(in_code), 32'(vecs[i].exp_code));
            check($sformatf("vec[%0d] %s reject", i, vecs[i].name), 32'(reject), 32'(vecs[i].exp_rej));
        end

`ifdef COIN_ACCEPTOR_TOTAL_EN
        @(negedge clk);
        total_clr = 1'b1;
        @(posedge clk);
        #1;
        check("coin_total initial clear", 32'(coin_total), 32'd0);
        @(negedge clk);
        total_clr = 1'b0;
        insert_coin(1'b1, 3'd2);
        insert_coin(1'b0, 3'd3);
        insert_coin(1'b1, 3'd5);
        insert_coin(1'b1, 3'd7);
        insert_coin(1'b1, 3'd7);
        @(negedge clk);
        total_clr = 1'b1;
        @(posedge clk);
        #1;
        check("coin_total clear", 32'(coin_total), 32'd0);
        @(negedge clk);
        total_clr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
